tfifo_counted: RTL and testbench

- Data-carrying transparent FIFO with an occupancy output; next generation of the dataless transparent FIFO.
- With BYPASS_EN=1, a token passes combinationally when the buffer is empty and the consumer is ready. Otherwise it is stored in a NUM_SLOTS circular buffer.
- Used on handshake channels that need slack without added latency. Buffer-pressure status feeds occupancy-aware placement and debug.

---
 rtl/tfifo_counted_pkg.sv | 14 +
 rtl/tfifo_counted_inner.sv | 78 +++++++
 rtl/tfifo_counted.sv | 60 ++++++
 tb/tb_tfifo_counted.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tfifo_counted_pkg.sv
// Shared helpers for the counted transparent FIFO: width and pointer-wrap math.
package tfifo_counted_pkg;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Advance a circular-buffer pointer, wrapping to 0 after depth-1 (any depth).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tfifo_counted_inner.sv
// Elastic circular buffer with occupancy count and registered almost_full.
module elastic_fifo_inner_counted
  import tfifo_counted_pkg::*;
#(
  parameter int unsigned DATA_TYPE    = 32,
  parameter int unsigned NUM_SLOTS    = 2,
  parameter int unsigned AF_THRESHOLD = NUM_SLOTS - 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_TYPE-1:0]                    ins,
  input  logic                                    ins_valid,
  output logic                                    ins_ready,
  output logic [DATA_TYPE-1:0]                    outs,
  output logic                                    outs_valid,
  input  logic                                    outs_ready,
  output logic [clog2_min1(NUM_SLOTS+1)-1:0]      count,
  output logic                                    almost_full
);

  localparam int unsigned CW = clog2_min1(NUM_SLOTS + 1);
  localparam int unsigned PW = clog2_min1(NUM_SLOTS);

  logic [DATA_TYPE-1:0] mem_q [NUM_SLOTS];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 af_q, af_d;
  logic                 empty, full, enq, deq;

  // Handshake flags and head-of-queue view.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CW'(NUM_SLOTS));
    ins_ready  = !full || outs_ready;
    outs_valid = !empty;
    outs       = mem_q[rd_ptr_q];
    enq        = ins_valid && ins_ready;
    deq        = !empty && outs_ready;
  end

  // Next pointers, occupancy and almost_full from the enq/deq pair.
  always_comb begin
    rd_ptr_d = deq ? PW'(ptr_inc(32'(rd_ptr_q), NUM_SLOTS)) : rd_ptr_q;
    wr_ptr_d = enq ? PW'(ptr_inc(32'(wr_ptr_q), NUM_SLOTS)) : wr_ptr_q;
    count_d  = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    af_d = (count_d >= CW'(AF_THRESHOLD));
  end

  // Control state; reset drops every stored token at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end

  // Payload storage, not reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[wr_ptr_q] <= ins;
  end

  assign count       = count_q;
  assign almost_full = af_q;

endmodule

// File: rtl/tfifo_counted.sv
// Transparent data FIFO: optional zero-latency bypass around a counted buffer.
module tfifo_counted
  import tfifo_counted_pkg::*;
#(
  parameter int unsigned DATA_TYPE    = 32,
  parameter int unsigned NUM_SLOTS    = 2,
  parameter int unsigned BYPASS_EN    = 1,
  parameter int unsigned AF_THRESHOLD = NUM_SLOTS - 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_TYPE-1:0]               ins,
  input  logic                               ins_valid,
  output logic                               ins_ready,
  output logic [DATA_TYPE-1:0]               outs,
  output logic                               outs_valid,
  input  logic                               outs_ready,
  output logic [clog2_min1(NUM_SLOTS+1)-1:0] count,
  output logic                               almost_full
);

  logic [DATA_TYPE-1:0] buf_outs;
  logic                 buf_in_valid;
  logic                 buf_outs_valid;

  elastic_fifo_inner_counted #(
    .DATA_TYPE   (DATA_TYPE),
    .NUM_SLOTS   (NUM_SLOTS),
    .AF_THRESHOLD(AF_THRESHOLD)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (buf_in_valid),
    .ins_ready  (ins_ready),
    .outs       (buf_outs),
    .outs_valid (buf_outs_valid),
    .outs_ready (outs_ready),
    .count      (count),
    .almost_full(almost_full)
  );

  if (BYPASS_EN != 0) begin : g_bypass
    // Buffer-side valid is masked when the token goes straight through, so the
    // inner enq equals ins_valid & ins_ready & (!outs_ready | !empty).
    always_comb begin
      buf_in_valid = ins_valid && (!outs_ready || buf_outs_valid);
      outs_valid   = ins_valid || buf_outs_valid;
      outs         = buf_outs_valid ? buf_outs : ins;
    end
  end else begin : g_elastic
    // Plain elastic path: every token is stored, no ins->outs combinational path.
    always_comb begin
      buf_in_valid = ins_valid;
      outs_valid   = buf_outs_valid;
      outs         = buf_outs;
    end
  end

endmodule

// File: tb/tb_tfifo_counted.sv
// Scoreboard bench for tfifo_counted: directed vectors plus randomized configs.
module tb_tfifo_counted;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rrst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rand_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- Directed DUT A: NUM_SLOTS=3, bypass ----------------
  logic [7:0] a_ins, a_outs;
  logic       a_iv, a_ir, a_ov, a_or, a_af;
  logic [1:0] a_cnt;
  logic [7:0] qa[$];
  logic [7:0] ea;

  tfifo_counted #(.DATA_TYPE(8), .NUM_SLOTS(3), .BYPASS_EN(1), .AF_THRESHOLD(2)) dut_a (
    .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ir),
    .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or), .count(a_cnt), .almost_full(a_af)
  );

  // ---------------- Directed DUT B: NUM_SLOTS=2, no bypass ----------------
  logic [7:0] b_ins, b_outs;
  logic       b_iv, b_ir, b_ov, b_or, b_af;
  logic [1:0] b_cnt;
  logic [7:0] qb[$];
  logic [7:0] eb;

  tfifo_counted #(.DATA_TYPE(8), .NUM_SLOTS(2), .BYPASS_EN(0), .AF_THRESHOLD(1)) dut_b (
    .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ir),
    .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or), .count(b_cnt), .almost_full(b_af)
  );

  // Output monitors: pop the expected token on every output handshake.
  always @(negedge clk) begin
    if (!rst && a_ov && a_or) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mon_a_unexpected: got %0h want none", a_outs);
      end else begin
        ea = qa.pop_front();
        check("mon_a_data", 32'(a_outs), 32'(ea));
      end
    end
    if (!rst && b_ov && b_or) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mon_b_unexpected: got %0h want none", b_outs);
      end else begin
        eb = qb.pop_front();
        check("mon_b_data", 32'(b_outs), 32'(eb));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    a_iv = 0; a_ins = '0; a_or = 0;
    b_iv = 0; b_ins = '0; b_or = 0;

    // Reset: combinational path follows ins while rst is high.
    #2 a_iv = 1; a_ins = 8'h5A;
    #1;
    check("rst_a_valid", 32'(a_ov), 1);
    check("rst_a_data", 32'(a_outs), 32'h5A);
    check("rst_a_count", 32'(a_cnt), 0);
    check("rst_a_af", 32'(a_af), 0);
    check("rst_b_valid", 32'(b_ov), 0);
    a_iv = 0;
    @(posedge clk); #3 rst = 0;

    // Test 1: zero-latency bypass.
    step(); a_or = 1; a_iv = 1; a_ins = 8'hA5; qa.push_back(8'hA5);
    @(negedge clk);
    check("t1_valid0", 32'(a_ov), 1);
    check("t1_data0", 32'(a_outs), 32'hA5);
    check("t1_count0", 32'(a_cnt), 0);
    step(); a_ins = 8'h3C; qa.push_back(8'h3C);
    @(negedge clk);
    check("t1_data1", 32'(a_outs), 32'h3C);
    check("t1_count1", 32'(a_cnt), 0);
    step(); a_iv = 0;
    @(negedge clk);
    check("t1_idle_valid", 32'(a_ov), 0);
    check("t1_idle_count", 32'(a_cnt), 0);

    // Test 2: fill to full, then simultaneous enq+deq when full.
    step(); a_or = 0; a_iv = 1; a_ins = 8'd1; qa.push_back(8'd1);
    @(negedge clk);
    check("t2_ready0", 32'(a_ir), 1);
    check("t2_count0", 32'(a_cnt), 0);
    step(); a_ins = 8'd2; qa.push_back(8'd2);
    @(negedge clk);
    check("t2_count1", 32'(a_cnt), 1);
    check("t2_af1", 32'(a_af), 0);
    step(); a_ins = 8'd3; qa.push_back(8'd3);
    @(negedge clk);
    check("t2_count2", 32'(a_cnt), 2);
    check("t2_af2", 32'(a_af), 1);
    step(); a_ins = 8'd4; qa.push_back(8'd4);
    @(negedge clk);
    check("t2_count3", 32'(a_cnt), 3);
    check("t2_af3", 32'(a_af), 1);
    check("t2_full_ready", 32'(a_ir), 0);
    check("t2_head", 32'(a_outs), 1);
    step();
    @(negedge clk);
    check("t2_hold_ready", 32'(a_ir), 0);
    check("t2_hold_count", 32'(a_cnt), 3);
    step(); a_or = 1;
    @(negedge clk);
    check("t2_swap_ready", 32'(a_ir), 1);
    check("t2_swap_head", 32'(a_outs), 1);
    step(); a_iv = 0;
    @(negedge clk);
    check("t2_swap_count", 32'(a_cnt), 3);
    check("t2_next_head", 32'(a_outs), 2);
    step();
    @(negedge clk);
    check("t2_drain_c2", 32'(a_cnt), 2);
    step();
    @(negedge clk);
    check("t2_drain_c1", 32'(a_cnt), 1);
    check("t2_drain_af", 32'(a_af), 0);
    step();
    @(negedge clk);
    check("t2_drain_c0", 32'(a_cnt), 0);
    check("t2_drain_valid", 32'(a_ov), 0);

    // Test 3: stream 0..9 with toggling consumer; pointers wrap.
    for (int i = 0; i < 10; i++) qa.push_back(8'(i));
    sent = 0;
    for (int c = 0; c < 80 && sent < 10; c++) begin
      step(); a_iv = 1; a_ins = 8'(sent); a_or = (c % 2 == 0);
      @(negedge clk);
      if (a_ir) sent++;
    end
    check("t3_sent", 32'(sent), 10);
    for (int c = 0; c < 12 && qa.size() != 0; c++) begin
      step(); a_iv = 0; a_or = 1;
      @(negedge clk);
    end
    step(); a_iv = 0;
    @(negedge clk);
    check("t3_drained", 32'(qa.size()), 0);
    check("t3_count", 32'(a_cnt), 0);

    // Test 4: no-bypass instance, minimum latency of one cycle.
    step(); b_iv = 1; b_ins = 8'h07; b_or = 1; qb.push_back(8'h07);
    @(negedge clk);
    check("t4_valid_send", 32'(b_ov), 0);
    check("t4_count_send", 32'(b_cnt), 0);
    step(); b_iv = 0;
    @(negedge clk);
    check("t4_valid_next", 32'(b_ov), 1);
    check("t4_data_next", 32'(b_outs), 32'h07);
    check("t4_count_next", 32'(b_cnt), 1);
    step();
    @(negedge clk);
    check("t4_count_after", 32'(b_cnt), 0);
    check("t4_valid_after", 32'(b_ov), 0);

    // Test 5: asynchronous reset drops two stored tokens.
    step(); a_or = 0; a_iv = 1; a_ins = 8'h11;
    step(); a_ins = 8'h22;
    step(); a_iv = 0;
    @(negedge clk);
    check("t5_count_pre", 32'(a_cnt), 2);
    check("t5_af_pre", 32'(a_af), 1);
    #2 rst = 1;
    #1;
    check("t5_count_rst", 32'(a_cnt), 0);
    check("t5_af_rst", 32'(a_af), 0);
    check("t5_valid_rst", 32'(a_ov), 0);
    @(posedge clk); #3 rst = 0;
    step(); a_iv = 1; a_ins = 8'h55; a_or = 1; qa.push_back(8'h55);
    @(negedge clk);
    check("t5_byp_valid", 32'(a_ov), 1);
    check("t5_byp_data", 32'(a_outs), 32'h55);
    check("t5_byp_count", 32'(a_cnt), 0);
    step(); a_iv = 0;
    @(negedge clk);
    check("t5_no_old", 32'(a_ov), 0);

    // Wait for the randomized instances, bounded.
    for (int c = 0; c < 20000 && rand_done < 6; c++) @(posedge clk);
    check("rand_done", 32'(rand_done), 6);
    check("qa_empty", 32'(qa.size()), 0);
    check("qb_empty", 32'(qb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- Randomized configs {1,2,5} x {bypass 0,1} ----------------
  initial begin
    #23 rrst = 0;
  end

  for (genvar g = 0; g < 6; g++) begin : g_rand
    localparam int unsigned N   = (g < 2) ? 1 : ((g < 4) ? 2 : 5);
    localparam int unsigned BYP = g % 2;
    localparam int unsigned AF  = (N == 5) ? 3 : 1;
    localparam int unsigned CWR = $clog2(N + 1);

    logic [7:0]     r_ins, r_outs;
    logic           r_iv, r_ir, r_ov, r_or, r_af;
    logic [CWR-1:0] r_cnt;

    tfifo_counted #(.DATA_TYPE(8), .NUM_SLOTS(N), .BYPASS_EN(BYP), .AF_THRESHOLD(AF)) dut_r (
      .clk(clk), .rst(rrst), .ins(r_ins), .ins_valid(r_iv), .ins_ready(r_ir),
      .outs(r_outs), .outs_valid(r_ov), .outs_ready(r_or), .count(r_cnt), .almost_full(r_af)
    );

    initial begin
      logic [7:0] q[$];
      int  cnt;
      bit  af_m, exp_ir, exp_ov, acc, deq, byp;
      cnt = 0; af_m = 0;
      r_iv = 0; r_or = 0; r_ins = '0;
      wait (rrst == 1'b0);
      for (int c = 0; c < 10000; c++) begin
        step();
        r_iv  = ($urandom_range(0, 3) != 0);
        r_ins = 8'($urandom);
        r_or  = ((c % 2000) < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        exp_ir = (cnt < int'(N)) || r_or;
        exp_ov = (BYP != 0) ? (r_iv || cnt != 0) : (cnt != 0);
        check($sformatf("rnd%0d_ready", g), 32'(r_ir), 32'(exp_ir));
        check($sformatf("rnd%0d_valid", g), 32'(r_ov), 32'(exp_ov));
        check($sformatf("rnd%0d_count", g), 32'(r_cnt), 32'(cnt));
        check($sformatf("rnd%0d_af", g), 32'(r_af), 32'(af_m));
        if (exp_ov && r_or)
          check($sformatf("rnd%0d_data", g), 32'(r_outs), (cnt == 0) ? 32'(r_ins) : 32'(q[0]));
        acc = r_iv && exp_ir;
        deq = (cnt != 0) && r_or;
        byp = (BYP != 0) && (cnt == 0) && r_or && r_iv;
        if (deq) void'(q.pop_front());
        if (acc && !byp) q.push_back(r_ins);
        cnt = cnt + ((acc && !byp) ? 1 : 0) - (deq ? 1 : 0);
        af_m = (cnt >= int'(AF));
      end
      rand_done++;
    end
  end

endmodule
